// File: rtl/mcdl_pkg.sv
// rtl/mcdl_pkg.sv - shared helpers for the multi-channel delay line
package mcdl_pkg;

    // Limit a requested delay to the legal 1..max_delay range.
    function automatic int clamp_delay(input int value, input int max_delay);
        if (value < 1)
            return 1;
        else if (value > max_delay)
            return max_delay;
        else
            return value;
    endfunction

    // Low bit of a lane inside a flat lane-packed bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/multi_chan_delay_line_delay_chan.sv
// rtl/multi_chan_delay_line_delay_chan.sv - one channel's valid/data shift register with flush and tap select
module delay_chan #(
    parameter int WIDTH     = 3,
    parameter int MAX_DELAY = 16,
    parameter int DW        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [DW-1:0]    delay,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [MAX_DELAY-1:0] stage_valid;
    logic [WIDTH-1:0]     stage_data [MAX_DELAY];

    // Stage 0 always captures so a flushed channel restarts at the new latency immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
            for (int k = 0; k < MAX_DELAY; k++)
                stage_data[k] <= '0;
        end else begin
            stage_valid[0] <= in_valid;
            stage_data[0]  <= in_data;
            for (int k = 1; k < MAX_DELAY; k++) begin
                if (flush) begin
                    stage_valid[k] <= 1'b0;
                    stage_data[k]  <= '0;
                end else begin
                    stage_valid[k] <= stage_valid[k-1];
                    stage_data[k]  <= stage_data[k-1];
                end
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (delay == DW'(k + 1)) begin
                out_valid = stage_valid[k];
                out_data  = stage_valid[k] ? stage_data[k] : '0;
            end
        end
    end

endmodule

// File: rtl/multi_chan_delay_line.sv
// rtl/multi_chan_delay_line.sv - per-channel run-time programmable clock-cycle delay line
module multi_chan_delay_line
    import mcdl_pkg::*;
#(
    parameter int NCH           = 3,
    parameter int WIDTH         = 3,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 1,
    localparam int DW           = $clog2(MAX_DELAY + 1),
    localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [DW-1:0]        cfg_delay,
    output logic                 cfg_err,
    output logic [NCH*DW-1:0]    cur_delay
);

    logic          ch_ok;
    logic          delay_bad;
    logic [DW-1:0] new_delay;
    logic [NCH-1:0] flush;
    logic [DW-1:0] cur_d [NCH];

    always_comb begin
        ch_ok     = int'(cfg_ch) < NCH;
        delay_bad = (cfg_delay == '0) || (int'(cfg_delay) > MAX_DELAY);
        new_delay = DW'(clamp_delay(int'(cfg_delay), MAX_DELAY));
        flush     = '0;
        for (int c = 0; c < NCH; c++)
            flush[c] = cfg_we && ch_ok && (cfg_ch == CW'(c));
    end

    // A clamped write is still applied; only an out-of-range channel leaves state alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
            for (int c = 0; c < NCH; c++)
                cur_d[c] <= DW'(DEFAULT_DELAY);
        end else begin
            cfg_err <= cfg_we && (!ch_ok || delay_bad);
            for (int c = 0; c < NCH; c++)
                if (flush[c])
                    cur_d[c] <= new_delay;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        delay_chan #(
            .WIDTH     (WIDTH),
            .MAX_DELAY (MAX_DELAY),
            .DW        (DW)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush[i]),
            .in_data   (in_data[lane_lo(i, WIDTH) +: WIDTH]),
            .in_valid  (in_valid[i]),
            .delay     (cur_d[i]),
            .out_data  (out_data[lane_lo(i, WIDTH) +: WIDTH]),
            .out_valid (out_valid[i])
        );

        assign cur_delay[lane_lo(i, DW) +: DW] = cur_d[i];
    end

endmodule

// File: doc/multi_chan_delay_line.md
Name: multi_chan_delay_line

Overview:
- Parametrised, per-channel programmable clock-cycle delay line for NCH independent channels of WIDTH-bit data with a valid qualifier.
- Next generation of the fixed a/b/c delay block: delays are whole clock cycles, set at run time per channel through a config port.
- Sits between producer and consumer stages that need latency alignment, e.g. skew compensation between parallel datapaths.

Parameters:
- NCH, 3, number of independent channels (≥1)
- WIDTH, 3, data bits per channel (≥1)
- MAX_DELAY, 16, largest supported delay in cycles (≥1)
- DEFAULT_DELAY, 1, delay loaded into every channel on reset (1..MAX_DELAY)
- DW, $clog2(MAX_DELAY+1), derived width of delay fields (localparam, not overridable)
- CW, max(1,$clog2(NCH)), derived width of channel index (localparam)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- in_data  in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel sample qualifier
- out_data  out  NCH*WIDTH  delayed data, same packing
- out_valid  out  NCH  delayed qualifier
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_ch  in  CW  target channel index
- cfg_delay  in  DW  requested delay in cycles
- cfg_err  out  1  registered one-cycle error pulse
- cur_delay  out  NCH*DW  active delay per channel, same packing as data

Behaviour:
- Reset: every stage valid=0 and data=0; out_valid=0; out_data=0; cur_delay=DEFAULT_DELAY on all channels; cfg_err=0. Reset asserted mid-stream drops all in-flight samples; no output appears until new valid input after reset.
- Pipeline per channel: stages 0..MAX_DELAY-1, each holds {valid, data}. Each edge: stage[0] <= {in_valid[i], in_data[i]}; stage[k] <= stage[k-1]. Stages always shift; no stall and no backpressure.
- Output tap: out_valid[i]/out_data[i] = stage[d-1], where d = cur_delay[i]. The tap selection is combinational from registers only, with no input-to-output combinational path.
- Latency: a sample present before edge N appears on the outputs after edge N+d-1, which is d register stages.
- out_data[i] is forced to 0 whenever out_valid[i]=0.
- Invalid input cycles propagate as bubbles. Back-to-back valid samples give back-to-back valid outputs at full throughput.
- Config write, evaluated at an edge with cfg_we=1 and reset=0:
  - cfg_ch ≥ NCH: no state change; cfg_err=1 on the next cycle.
  - cfg_delay = 0: clamp to 1 and set cfg_err=1.
  - cfg_delay > MAX_DELAY: clamp to MAX_DELAY and set cfg_err=1.
  - Otherwise apply cfg_delay as given; cfg_err=0.
  - Accepted write (clamped or not): cur_delay[ch] updates at that edge. The same edge clears stage[1..MAX_DELAY-1] valid and data for that channel, flushing in-flight samples. Stage[0] still captures in_data/in_valid at that edge, so the new stream starts immediately at the new latency. No old sample is ever emitted after the write. Other channels are unaffected.
  - A write with cfg_delay equal to the current value still flushes.
- cfg_err is high for exactly one cycle per offending write. Consecutive bad writes keep it high on consecutive cycles.
- Simultaneous reset and cfg_we: reset wins and cur_delay goes to DEFAULT_DELAY.

Decomposition:
- Package mcdl_pkg holds helper function clamp_delay(value, max) -> DW bits and the packing index helpers.
- One sub-module, delay_chan: a single channel's MAX_DELAY-stage valid/data shift register with flush input and tap select.
- The top instantiates NCH copies of delay_chan via generate and owns the config decode and cfg_err register.

Test Plan:
- Reset defaults: hold reset 2 cycles -> out_valid=0, out_data=0, cur_delay all =1, cfg_err=0.
- Latency per channel: set ch0=1, ch1=5, ch2=16, then drive a valid ramp 1,2,3... on all channels -> ch0 output matches input 1 cycle later, ch1 5 cycles later, ch2 16 cycles later, with no gaps or duplicates.
- Bubbles: in_valid pattern 1,0,1,1,0 with data A,x,B,C,x at delay 4 -> the same pattern appears 4 cycles later, and out_data=0 on the invalid cycles.
- Reconfigure mid-stream: ch1 at delay 8 with a continuous stream, then write delay 3 -> no old samples are emitted; the first output is the sample captured at the write edge, appearing 3 cycles later; ch0 and ch2 are undisturbed.
- Bad config: write cfg_delay=0 -> cur_delay=1 and cfg_err pulses. Write 20 with MAX_DELAY=16 -> cur_delay=16 and cfg_err pulses. Write cfg_ch=3 with NCH=3 -> no change and cfg_err pulses.
- Reset mid-operation: assert reset while 5 samples are in flight at delay 6 -> none emerge afterwards and cur_delay returns to 1. A simultaneous cfg_we is ignored.
